// File: rtl/alu1_if.sv
// Operand/result bundle for the alu1 slice array: operands, carry-in and op code
// travel towards the ALU, the registered result and carry-out travel back.
interface alu1_if #(
  parameter int WIDTH = 1
) ();
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             cin;
  logic [1:0]       op;
  logic [WIDTH-1:0] y;
  logic             cout;

  modport master (output i0, i1, cin, op, input y, cout);
  modport slave  (input i0, i1, cin, op, output y, cout);
endinterface

// File: rtl/alu1.sv
// Registered ripple-carry ALU: AND, OR, ADD, SUB over WIDTH bit slices with
// carry-in, one cycle of latency, async active-low reset on the outputs.
module alu1 #(
  parameter int WIDTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  alu1_if.slave  bus
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  logic [WIDTH-1:0] y_d, y_q;
  logic             cout_d, cout_q;
  logic [WIDTH:0]   chain;

  // Per-slice full adder chain; returns {carry out of MSB, sum bits}.
  function automatic logic [WIDTH:0] ripple(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             c0);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    c[0] = c0;
    for (int k = 0; k < WIDTH; k++) begin
      s[k]   = a[k] ^ b[k] ^ c[k];
      c[k+1] = (a[k] & b[k]) | (a[k] & c[k]) | (b[k] & c[k]);
    end
    return {c[WIDTH], s};
  endfunction

  // Stage: combinational slice logic
  always_comb begin
    y_d    = '0;
    cout_d = 1'b0;
    chain  = ripple(bus.i0, (bus.op == OP_SUB) ? ~bus.i1 : bus.i1, bus.cin);
    case (bus.op)
      OP_AND: y_d = bus.i0 & bus.i1;
      OP_OR:  y_d = bus.i0 | bus.i1;
      OP_ADD, OP_SUB: begin
        y_d    = chain[WIDTH-1:0];
        cout_d = chain[WIDTH];
      end
      default: begin
        y_d    = '0;
        cout_d = 1'b0;
      end
    endcase
  end

  // Stage: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      cout_q <= cout_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_alu1.sv
// Bench for alu1: drives a 1-bit and an 8-bit instance from shared stimulus and
// compares both against an arithmetic reference of the previous edge's inputs.
module tb_alu1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu1_if #(.WIDTH(8)) b8 ();
  alu1_if #(.WIDTH(1)) b1 ();

  alu1 #(.WIDTH(8)) u_alu8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  alu1 #(.WIDTH(1)) u_alu1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {cout, y} from plain arithmetic on a w-bit view of the operands.
  function automatic logic [64:0] ref_alu(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic c,
                                          input logic [1:0] op);
    logic [63:0] m;
    logic [64:0] s;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a & m;
    b = b & m;
    case (op)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   s = {1'b0, a} + {1'b0, b} + {64'd0, c};
      default: s = {1'b0, a} + {1'b0, (~b) & m} + {64'd0, c};
    endcase
    return {s[w], s[63:0] & m};
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [1:0] op);
    b8.i0 = a;    b8.i1 = b;    b8.cin = c; b8.op = op;
    b1.i0 = a[0]; b1.i1 = b[0]; b1.cin = c; b1.op = op;
  endtask

  // Apply one operation at the negedge, check after the edge, scramble inputs
  // mid-cycle and check that the outputs held.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [1:0] op);
    logic [64:0] e8, e1;
    e8 = ref_alu(8, {56'd0, a}, {56'd0, b}, c, op);
    e1 = ref_alu(1, {56'd0, a}, {56'd0, b}, c, op);
    drive(a, b, c, op);
    @(posedge clk);
    #1;
    chk({tag, "_y8"},  {56'd0, b8.y},  e8[63:0]);
    chk({tag, "_c8"},  {63'd0, b8.cout}, {63'd0, e8[64]});
    chk({tag, "_y1"},  {63'd0, b1.y},  e1[63:0]);
    chk({tag, "_c1"},  {63'd0, b1.cout}, {63'd0, e1[64]});
    #2;
    drive(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
    @(negedge clk);
    chk({tag, "_hold8"}, {55'd0, b8.cout, b8.y}, {55'd0, e8[64], e8[7:0]});
    chk({tag, "_hold1"}, {62'd0, b1.cout, b1.y}, {62'd0, e1[64], e1[0]});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(8'd0, 8'd0, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y8", {56'd0, b8.y}, 64'd0);
    chk("rst_c8", {63'd0, b8.cout}, 64'd0);
    chk("rst_y1", {63'd0, b1.y}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with literal expectations
    step("and1", 8'h01, 8'h01, 1'b0, 2'b00);
    chk("t1_y", {63'd0, b1.y}, 64'd1);
    chk("t1_c", {63'd0, b1.cout}, 64'd0);
    step("or1", 8'h01, 8'h01, 1'b1, 2'b01);
    chk("t2_or_y", {63'd0, b1.y}, 64'd1);
    chk("t2_or_c", {63'd0, b1.cout}, 64'd0);
    step("add1", 8'h01, 8'h01, 1'b0, 2'b10);
    chk("t2_add_y", {63'd0, b1.y}, 64'd0);
    chk("t2_add_c", {63'd0, b1.cout}, 64'd1);
    step("sub1", 8'h01, 8'h01, 1'b1, 2'b11);
    chk("t2_sub_y", {63'd0, b1.y}, 64'd0);
    chk("t2_sub_c", {63'd0, b1.cout}, 64'd1);
    step("add8a", 8'hFF, 8'h01, 1'b0, 2'b10);
    chk("t3a", {55'd0, b8.cout, b8.y}, {55'd0, 1'b1, 8'h00});
    step("add8b", 8'hFF, 8'h01, 1'b1, 2'b10);
    chk("t3b", {55'd0, b8.cout, b8.y}, {55'd0, 1'b1, 8'h01});
    step("sub8a", 8'h05, 8'h07, 1'b1, 2'b11);
    chk("t4a", {55'd0, b8.cout, b8.y}, {55'd0, 1'b0, 8'hFE});
    step("sub8b", 8'h07, 8'h05, 1'b1, 2'b11);
    chk("t4b", {55'd0, b8.cout, b8.y}, {55'd0, 1'b1, 8'h02});
    step("sub8c", 8'h07, 8'h05, 1'b0, 2'b11);
    chk("t4c", {55'd0, b8.cout, b8.y}, {55'd0, 1'b1, 8'h01});

    // Mid-cycle reset clears outputs at once and holds across an edge
    step("pre_rst", 8'h01, 8'h01, 1'b0, 2'b10);
    chk("pre_rst_c1", {63'd0, b1.cout}, 64'd1);
    drive(8'h01, 8'h01, 1'b0, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_y8", {55'd0, b8.cout, b8.y}, 64'd0);
    chk("async_y1", {62'd0, b1.cout, b1.y}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold8", {55'd0, b8.cout, b8.y}, 64'd0);
    chk("rst_hold1", {62'd0, b1.cout, b1.y}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 8'h80, 8'h80, 1'b1, 2'b10);
    chk("post_rst8", {55'd0, b8.cout, b8.y}, {55'd0, 1'b1, 8'h01});

    // Random back-to-back operations
    for (int i = 0; i < 200; i++) begin
      step("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
